reg_file_mp: RTL

Parametrised multi-port integer register file for the RV32 core. It provides NRD combinational read ports, NWR synchronous write ports with fixed priority, and a hardwired-zero register 0. A per-register busy scoreboard lets the issue stage stall on pending producers. It replaces the single-write, two-read file in the datapath and adds asynchronous reset of all architectural state.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 63 ++++++
 rtl/reg_file_mp.sv | 105 ++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults, types and reset value for the multi-port integer register file.
// Consumers: rf_scoreboard, reg_file_mp (optional bypass via REG_FILE_MP_BYPASS_EN).
package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 1;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

    localparam reg_data_t REG_RESET_VAL = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on producer issue, cleared by the producer's write.
// With REG_FILE_MP_BYPASS_EN, a same-cycle write hides busy on the matching read port.
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wa,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears first, then the set: a new producer supersedes the one retiring now.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && (wa[j*AW +: AW] != '0)) begin
                busy_d[wa[j*AW +: AW]] = 1'b0;
            end
        end
        if (sb_set && (sb_addr != '0)) begin
            busy_d[sb_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy_q[ra[i*AW +: AW]];
`ifdef REG_FILE_MP_BYPASS_EN
            if (rst_n && (ra[i*AW +: AW] != '0) &&
                !(sb_set && (sb_addr == ra[i*AW +: AW]))) begin
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (wa[j*AW +: AW] == ra[i*AW +: AW])) begin
                        rd_busy[i] = 1'b0;
                    end
                end
            end
`endif
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port RV32 integer register file: NRD combinational reads, NWR prioritised writes, x0 = 0.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr
);

    if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("reg_file_mp: NREGS must be a power of two and at least 2");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("reg_file_mp: NRD must be in 1..4");
    end
    if (NWR < 1 || NWR > 2) begin : g_bad_nwr
        $error("reg_file_mp: NWR must be in 1..2");
    end

    // Register 0 has no storage; index 0 of the view below is tied to zero.
    logic [XLEN-1:0] rf_q    [1:NREGS-1];
    logic [XLEN-1:0] rf_d    [1:NREGS-1];
    logic [XLEN-1:0] rf_view [0:NREGS-1];

    // Ascending port order lets the higher-index port win an address collision.
    always_comb begin
        for (int r = 1; r < NREGS; r++) begin
            rf_d[r] = rf_q[r];
        end
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && (wa[j*AW +: AW] != '0)) begin
                rf_d[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NREGS; r++) begin
                rf_q[r] <= XLEN'(REG_RESET_VAL);
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                rf_q[r] <= rf_d[r];
            end
        end
    end

    // Named per-register values (g_reg[n].value) for waveform inspection.
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        logic [XLEN-1:0] value;
        if (r == 0) begin : g_zero
            assign value = '0;
        end else begin : g_store
            assign value = rf_q[r];
        end
        assign rf_view[r] = value;
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NRD; i++) begin
            rd[i*XLEN +: XLEN] = rf_view[ra[i*AW +: AW]];
`ifdef REG_FILE_MP_BYPASS_EN
            // Forwarding is suppressed in reset so reads stay zero there.
            for (int j = 0; j < NWR; j++) begin
                if (rst_n && we[j] && (ra[i*AW +: AW] != '0) &&
                    (wa[j*AW +: AW] == ra[i*AW +: AW])) begin
                    rd[i*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
                end
            end
`endif
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .wa      (wa),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .ra      (ra),
        .rd_busy (rd_busy)
    );

endmodule
